// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbitrating multiplexer and its picker.
package arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

    // Channel-id width; a single-bit id is kept even for degenerate counts.
    function automatic int ch_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// Rotating priority picker: first set request at or above ptr, wrapping.
// A pointer tied to zero degenerates into lowest-index-wins.
module arb_rr_picker #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    logic [2*NUM_CH-1:0] dbl;
    logic [2*NUM_CH-1:0] masked;

    // Upper copy of the request vector supplies the wrapped-around channels.
    always_comb begin
        dbl    = {req, req};
        masked = '0;
        for (int j = 0; j < 2*NUM_CH; j++) begin
            masked[j] = dbl[j] && (j >= int'(ptr));
        end
    end

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int j = 2*NUM_CH-1; j >= 0; j--) begin
            if (masked[j]) begin
                any = 1'b1;
                idx = (j >= NUM_CH) ? IDX_W'(j - NUM_CH) : IDX_W'(j);
            end
        end
        gnt = any ? (NUM_CH'(1) << idx) : '0;
    end

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrating mux with a single registered valid/ready output stage.
module arb_mux
    import arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int RR_EN      = 1,
    parameter int ID_W       = ch_id_w(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         arstn,
    input  logic [NUM_CH-1:0]            i_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
    output logic [NUM_CH-1:0]            o_ready,
    output logic                         o_valid,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [ID_W-1:0]              o_ch_id,
    input  logic                         i_ready
);

    localparam arb_mode_t MODE = (RR_EN != 0) ? ARB_RR : ARB_FIXED;

    logic                  o_valid_q, o_valid_d;
    logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
    logic [ID_W-1:0]       o_ch_id_q, o_ch_id_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       pick_ptr;
    logic [ID_W-1:0]       win_idx;
    logic [NUM_CH-1:0]     gnt;
    logic                  win_any;
    logic                  load_en;
    logic                  xfer;

    // Fixed priority pins the pointer at zero so the register folds away.
    assign pick_ptr = (MODE == ARB_RR) ? ptr_q : '0;

    arb_rr_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (ID_W)
    ) u_picker (
        .req (i_valid),
        .ptr (pick_ptr),
        .gnt (gnt),
        .idx (win_idx),
        .any (win_any)
    );

    assign load_en = !o_valid_q || i_ready;
    assign o_ready = (arstn && load_en) ? gnt : '0;
    assign xfer    = arstn && load_en && win_any;

    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_ch_id_d = o_ch_id_q;
        ptr_d     = ptr_q;
        if (xfer) begin
            o_valid_d = 1'b1;
            o_data_d  = i_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
            o_ch_id_d = win_idx;
            if (MODE == ARB_RR) begin
                // Explicit wrap keeps non-power-of-2 channel counts in range.
                ptr_d = (win_idx == ID_W'(NUM_CH-1)) ? '0 : win_idx + 1'b1;
            end
        end else if (i_ready) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_ch_id_q <= '0;
            ptr_q     <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_ch_id_q <= o_ch_id_d;
            ptr_q     <= ptr_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_ch_id = o_ch_id_q;

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux: RR x4, fixed x4 and RR x3 instances side by side.
module tb_arb_mux;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    int nch [NI] = '{4, 4, 3};
    int rr  [NI] = '{1, 0, 1};

    logic [3:0]  val [NI];
    logic [31:0] dat [NI][4];
    logic        ir  [NI];

    logic [127:0] d0, d1;
    logic [95:0]  d2;
    logic [3:0]   r0, r1;
    logic [2:0]   r2;
    logic         v0, v1, v2;
    logic [31:0]  o0, o1, o2;
    logic [1:0]   id0, id1, id2;
    logic [2:0]   val2;

    logic [3:0]  ordy [NI];
    logic        ov   [NI];
    logic [31:0] od   [NI];
    logic [1:0]  oid  [NI];

    always_comb begin
        d0 = '0; d1 = '0; d2 = '0;
        for (int k = 0; k < 4; k++) begin
            d0[k*32 +: 32] = dat[0][k];
            d1[k*32 +: 32] = dat[1][k];
        end
        for (int k = 0; k < 3; k++) d2[k*32 +: 32] = dat[2][k];
    end
    assign val2 = val[2][2:0];

    arb_mux #(.DATA_WIDTH(32), .NUM_CH(4), .RR_EN(1)) u0 (
        .clk(clk), .arstn(arstn), .i_valid(val[0]), .i_data(d0), .o_ready(r0),
        .o_valid(v0), .o_data(o0), .o_ch_id(id0), .i_ready(ir[0]));
    arb_mux #(.DATA_WIDTH(32), .NUM_CH(4), .RR_EN(0)) u1 (
        .clk(clk), .arstn(arstn), .i_valid(val[1]), .i_data(d1), .o_ready(r1),
        .o_valid(v1), .o_data(o1), .o_ch_id(id1), .i_ready(ir[1]));
    arb_mux #(.DATA_WIDTH(32), .NUM_CH(3), .RR_EN(1)) u2 (
        .clk(clk), .arstn(arstn), .i_valid(val2), .i_data(d2), .o_ready(r2),
        .o_valid(v2), .o_data(o2), .o_ch_id(id2), .i_ready(ir[2]));

    assign ordy[0] = r0;  assign ordy[1] = r1;  assign ordy[2] = {1'b0, r2};
    assign ov[0]   = v0;  assign ov[1]   = v1;  assign ov[2]   = v2;
    assign od[0]   = o0;  assign od[1]   = o1;  assign od[2]   = o2;
    assign oid[0]  = id0; assign oid[1]  = id1; assign oid[2]  = id2;

    typedef struct {
        logic [31:0] d;
        int          id;
    } exp_t;

    exp_t        sbq [NI][$];
    exp_t        mon_e;
    int          ntests = 0;
    int          nfail  = 0;
    int          mptr [NI];
    bit          mv   [NI];
    int          xk   [NI];
    int          dgnt [NI];
    bit          hold [NI][4];
    logic [31:0] hdat [NI][4];

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s inst%0d got=%h exp=%h t=%0t", nm, i, got, exp, $time);
        end
    endtask

    // Monitor: each cycle the output is valid and drained, one item leaves.
    always @(negedge clk) begin
        if (arstn) begin
            for (int i = 0; i < NI; i++) begin
                if (ov[i] && ir[i]) begin
                    if (sbq[i].size() == 0) begin
                        ntests++;
                        nfail++;
                        $display("FAIL sb_empty inst%0d got=output item exp=none", i);
                    end else begin
                        mon_e = sbq[i].pop_front();
                        chk("sb_data", i, od[i], mon_e.d);
                        chk("sb_id", i, 32'(oid[i]), 32'(mon_e.id));
                    end
                end
            end
        end
    end

    // One cycle: check handshake against the reference model at the negedge,
    // advance the model, then return just after the following posedge.
    task automatic step();
        int g;
        int k;
        bit le;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            dgnt[i] = -1;
            for (int c = 0; c < nch[i]; c++) if (ordy[i][c]) dgnt[i] = c;
            for (int c = 0; c < nch[i]; c++)
                if (hold[i][c])
                    chk("src_hold", i, 32'({val[i][c], dat[i][c] == hdat[i][c]}), 32'd3);
            if (!arstn) begin
                chk("rst_ovalid", i, 32'(ov[i]), 32'd0);
                chk("rst_odata", i, od[i], 32'd0);
                chk("rst_id", i, 32'(oid[i]), 32'd0);
                chk("rst_ready", i, 32'(ordy[i]), 32'd0);
                mv[i] = 1'b0;
                mptr[i] = 0;
                xk[i] = -1;
                sbq[i].delete();
            end else begin
                le = !mv[i] || ir[i];
                g = -1;
                if (le) begin
                    for (int j = 0; j < nch[i]; j++) begin
                        k = (rr[i] != 0) ? (mptr[i] + j) % nch[i] : j;
                        if (g < 0 && val[i][k]) g = k;
                    end
                end
                chk("ready", i, 32'(ordy[i]), (g >= 0) ? (32'd1 << g) : 32'd0);
                chk("ovalid", i, 32'(ov[i]), 32'(mv[i]));
                xk[i] = g;
                if (g >= 0) begin
                    sbq[i].push_back('{d: dat[i][g], id: g});
                    mptr[i] = (g + 1) % nch[i];
                    mv[i] = 1'b1;
                end else if (mv[i] && ir[i]) begin
                    mv[i] = 1'b0;
                end
            end
            for (int c = 0; c < nch[i]; c++) begin
                hold[i][c] = arstn && val[i][c] && !ordy[i][c];
                hdat[i][c] = dat[i][c];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [3:0] v, input logic r);
        for (int i = 0; i < NI; i++) begin
            val[i] = (i == 2) ? (v & 4'b0111) : v;
            ir[i]  = r;
        end
    endtask

    task automatic do_reset();
        arstn = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) chk("rst_async", i, 32'(ov[i]), 32'd0);
        repeat (2) step();
        arstn = 1'b1;
    endtask

    task automatic refill(input int vpct, input int rpct);
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < nch[i]; c++) begin
                if (!val[i][c] || xk[i] == c) begin
                    val[i][c] = (int'($urandom_range(0, 99)) < vpct);
                    dat[i][c] = $urandom;
                end
            end
            ir[i] = (int'($urandom_range(0, 99)) < rpct);
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            mptr[i] = 0; mv[i] = 1'b0; xk[i] = -1; dgnt[i] = -1;
            val[i] = '0; ir[i] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                dat[i][c] = $urandom; hold[i][c] = 1'b0; hdat[i][c] = '0;
            end
        end

        // Reset with random requests pending, then idle.
        arstn = 1'b0;
        repeat (3) begin
            for (int i = 0; i < NI; i++) val[i] = 4'($urandom);
            step();
        end
        set_all(4'b0000, 1'b1);
        arstn = 1'b1;
        repeat (2) step();
        for (int i = 0; i < NI; i++) chk("idle_ovalid", i, 32'(ov[i]), 32'd0);

        // Single channel request.
        for (int i = 0; i < NI; i++) dat[i][2] = 32'hDEAD_BEEF;
        set_all(4'b0100, 1'b1);
        step();
        for (int i = 0; i < NI; i++) begin
            chk("single_grant", i, 32'(dgnt[i]), 32'd2);
            chk("single_valid", i, 32'(ov[i]), 32'd1);
            chk("single_data", i, od[i], 32'hDEAD_BEEF);
            chk("single_id", i, 32'(oid[i]), 32'd2);
        end
        set_all(4'b0000, 1'b1);
        step();

        // Fairness with every channel valid; fixed priority keeps picking 0.
        do_reset();
        set_all(4'b1111, 1'b1);
        for (int n = 0; n < 8; n++) begin
            step();
            for (int i = 0; i < NI; i++)
                chk("fair_seq", i, 32'(dgnt[i]), (rr[i] != 0) ? 32'(n % nch[i]) : 32'd0);
        end
        // Reset mid-stream: output drops at once, first grant afterwards is 0.
        arstn = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) chk("mid_rst_ovalid", i, 32'(ov[i]), 32'd0);
        step();
        arstn = 1'b1;
        step();
        for (int i = 0; i < NI; i++) chk("post_rst_grant", i, 32'(dgnt[i]), 32'd0);

        // Fixed priority starves channel 3 until channel 1 drops.
        do_reset();
        set_all(4'b1010, 1'b1);
        repeat (4) begin
            step();
            chk("fixed_ch1", 1, 32'(dgnt[1]), 32'd1);
        end
        val[1] = 4'b1000;
        step();
        chk("fixed_ch3", 1, 32'(dgnt[1]), 32'd3);
        chk("fixed_id3", 1, 32'(oid[1]), 32'd3);

        // Back-pressure with channel 1 in the output register.
        do_reset();
        set_all(4'b1111, 1'b1);
        repeat (2) step();
        for (int i = 0; i < NI; i++) ir[i] = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            chk("stall_id", 0, 32'(oid[0]), 32'd1);
            chk("stall_ready", 0, 32'(ordy[0]), 32'd0);
        end
        for (int i = 0; i < NI; i++) ir[i] = 1'b1;
        step();
        chk("bp_next_rr", 0, 32'(dgnt[0]), 32'd2);
        chk("bp_next_fixed", 1, 32'(dgnt[1]), 32'd0);
        chk("bp_next_rr3", 2, 32'(dgnt[2]), 32'd2);

        // Randomized traffic against the model.
        for (int blk = 0; blk < 15; blk++) begin
            int vp;
            int rp;
            vp = int'($urandom_range(10, 100));
            rp = int'($urandom_range(30, 100));
            repeat (200) begin
                refill(vp, rp);
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
